debug_controller: RTL and testbench
===================================

Name: debug_controller

Overview:
- Parametrised successor to the UART debugger's command controller.
- Accepts decoded debug commands from the serial front end with a valid/ready handshake and returns exactly one response per command with a valid/ready handshake.
- Pauses, steps, resumes and resets the MCU; holds a NUM_BP-entry PC breakpoint table; performs bounded-time register-file and memory accesses on the paused MCU.

Parameters:
- XLEN, 32, width of address, data and pc.
- NUM_BP, 8, number of breakpoint slots (1..64); CNT_W = clog2(NUM_BP+1) is derived.
- TIMEOUT, 255, maximum cycles to wait for mcu_ack before an access is aborted.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- cmd  in  4  function code: 0 PAUSE, 1 RESUME, 2 STEP, 3 RESET, 4 STATUS, 5 BR_PT_ADD, 6 BR_PT_RM, 7 MEM_RD, 8 MEM_WR, 9 REG_RD, 10 REG_WR; 11..15 are illegal.
- cmd_addr  in  XLEN  breakpoint pc, memory address, or register index.
- cmd_data  in  XLEN  write data.
- cmd_valid  in  1  / cmd_ready  out  1  command handshake.
- rsp_valid  out  1  / rsp_ready  in  1  response handshake.
- rsp_data  out  XLEN  response data.
- rsp_err  out  1  response error flag.
- pc  in  XLEN  current MCU pc.
- mcu_busy  in  1  MCU mid-instruction.
- mcu_ack  in  1  access complete.
- mcu_rdata  in  XLEN  read data.
- pause  out  1  level; holds the MCU.
- flush  out  1  pipeline flush pulse.
- mcu_reset  out  1  MCU reset pulse.
- bp_hit  out  1  breakpoint hit pulse.
- mcu_addr  out  XLEN / mcu_wdata  out  XLEN  access address and write data.
- mem_rd, mem_wr, rf_rd, rf_wr  out  1 each  access strobes.

Behaviour:
- Reset (rst_n=0, any time, including mid-access):
  - State goes to IDLE; all breakpoint slots become invalid; count = 0.
  - Every output is 0 except cmd_ready, which is 1 once rst_n deasserts.
  - An in-flight strobe drops immediately; no response is issued for the aborted command.
- Command handshake:
  - A command is accepted when cmd_valid && cmd_ready.
  - cmd_ready = 1 only in IDLE with rsp_valid = 0.
  - cmd, cmd_addr and cmd_data are registered on acceptance.
- Response handshake:
  - rsp_valid, rsp_data and rsp_err are held stable until rsp_ready; the controller returns to IDLE on the rsp_ready cycle.
  - rsp_data = 0 unless stated otherwise.
- Paused definition: paused = pause && !mcu_busy.
- States: IDLE, PAUSING, STEP_RUN, STEP_STOP, ACCESS, RESPOND.
- PAUSE:
  - Sets pause = 1, then waits in PAUSING until mcu_busy = 0, then responds.
  - Minimum latency: rsp_valid in the cycle after acceptance.
  - If already paused, responds immediately.
- RESUME:
  - Clears pause and latches pc into sup_pc; sup = 1.
  - Responds the next cycle; RESUME while already running is not an error.
- STEP:
  - If not paused: rsp_err = 1.
  - Otherwise: pause = 0 for exactly 1 cycle (STEP_RUN), then pause = 1; STEP_STOP waits until mcu_busy = 0, then responds with rsp_data = pc.
  - Breakpoints are ignored during the step.
- RESET: mcu_reset = 1 and flush = 1 for one cycle; pause state and the breakpoint table are unchanged; responds the next cycle.
- STATUS: rsp_data[0] = paused, rsp_data[8+CNT_W-1:8] = breakpoint count.
- BR_PT_ADD:
  - cmd_addr already present: ok, no duplicate entry created.
  - Otherwise written into the lowest-index free slot; count+1.
  - Table full: rsp_err = 1, table unchanged.
- BR_PT_RM: invalidates the matching slot and decrements count; address not present: rsp_err = 1.
- Breakpoint compare:
  - Every cycle, when pause = 0, not stepping, and not (sup && pc == sup_pc): any valid slot equal to pc causes pause = 1 next cycle, with bp_hit = 1 and flush = 1 for one cycle.
  - sup clears as soon as pc != sup_pc.
- Memory and register-file commands (7..10):
  - Not paused: rsp_err = 1 with no strobe.
  - Paused: ACCESS drives mcu_addr = cmd_addr, mcu_wdata = cmd_data and exactly one strobe, held until mcu_ack.
    - Reads return mcu_rdata latched on the ack cycle.
    - Strobes drop in the cycle after the ack.
  - No ack after TIMEOUT cycles with the strobe high: strobe drops, rsp_err = 1.
- Illegal cmd (11..15): rsp_err = 1 with no side effects.
- Simultaneous breakpoint hit and command acceptance:
  - The hit is applied first: pause is set and bp_hit is pulsed once.
  - The command then executes against the paused state (e.g. an accepted RESUME clears pause, with sup_pc = pc).
- Widths: all pc and address comparisons use the full XLEN bits with no masking.

Test Plan:
- Reset mid-MEM_RD with mem_rd high → mem_rd = 0 within 0 cycles of rst_n low; no rsp_valid; after release cmd_ready = 1 and STATUS returns 0x0.
- ADD 0x100, 0x104, 0x100 → three ok responses and STATUS count = 2; with NUM_BP=2, ADD 0x108 → rsp_err = 1; RM 0x200 → rsp_err = 1.
- Breakpoint at 0x100, pc ramps 0xF8→0x100 → bp_hit and flush pulse once, pause = 1; RESUME at pc = 0x100 → no re-hit; pc → 0x104 → 0x100 → hit again.
- Paused, STEP with mcu_busy high for 3 cycles → pause low exactly 1 cycle; response after busy falls with rsp_data = new pc.
- Paused, REG_RD addr 5, ack after 4 cycles with rdata 0xDEADBEEF → rf_rd high 4 cycles, rsp_data = 0xDEADBEEF; MEM_WR with no ack, TIMEOUT=255 → strobe drops after 255 cycles, rsp_err = 1.
- Running, MEM_RD → immediate rsp_err = 1 with no strobe; rsp_ready held low 10 cycles → rsp_* stable and cmd_ready = 0 throughout.

Source files
------------

// File: rtl/debug_controller.sv
`default_nettype none
// ============================================================================
// Module   : debug_controller
// Desc     : Debug command controller: pause/step/resume/reset of the MCU,
//            PC breakpoint table, and bounded-time register/memory access.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module debug_controller #(
  parameter int XLEN    = 32,
  parameter int NUM_BP  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      i_cmd,
  input  logic [XLEN-1:0] i_cmd_addr,
  input  logic [XLEN-1:0] i_cmd_data,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_rsp_err,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_mcu_busy,
  input  logic            i_mcu_ack,
  input  logic [XLEN-1:0] i_mcu_rdata,
  output logic            o_pause,
  output logic            o_flush,
  output logic            o_mcu_reset,
  output logic            o_bp_hit,
  output logic [XLEN-1:0] o_mcu_addr,
  output logic [XLEN-1:0] o_mcu_wdata,
  output logic            o_mem_rd,
  output logic            o_mem_wr,
  output logic            o_rf_rd,
  output logic            o_rf_wr
);

  localparam int CNT_W = $clog2(NUM_BP + 1);
  localparam int IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;
  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [3:0] C_PAUSE  = 4'd0;
  localparam logic [3:0] C_RESUME = 4'd1;
  localparam logic [3:0] C_STEP   = 4'd2;
  localparam logic [3:0] C_RESET  = 4'd3;
  localparam logic [3:0] C_STATUS = 4'd4;
  localparam logic [3:0] C_BP_ADD = 4'd5;
  localparam logic [3:0] C_BP_RM  = 4'd6;
  localparam logic [3:0] C_MEM_RD = 4'd7;
  localparam logic [3:0] C_MEM_WR = 4'd8;
  localparam logic [3:0] C_REG_RD = 4'd9;
  localparam logic [3:0] C_REG_WR = 4'd10;

  typedef enum logic [2:0] {
    S_IDLE, S_PAUSING, S_STEP_RUN, S_STEP_STOP, S_ACCESS, S_RESPOND
  } state_t;

  state_t            r_state;
  logic [3:0]        r_cmd;
  logic [XLEN-1:0]   r_addr;
  logic [XLEN-1:0]   r_data;
  logic              r_pause;
  logic              r_sup;
  logic [XLEN-1:0]   r_sup_pc;
  logic [NUM_BP-1:0] r_bp_valid;
  logic [XLEN-1:0]   r_bp_addr [NUM_BP];
  logic [CNT_W-1:0]  r_count;
  logic              r_rsp_valid;
  logic [XLEN-1:0]   r_rsp_data;
  logic              r_rsp_err;
  logic              r_flush;
  logic              r_mcu_reset;
  logic              r_bp_hit;
  logic              r_mem_rd;
  logic              r_mem_wr;
  logic              r_rf_rd;
  logic              r_rf_wr;
  logic [TMR_W-1:0]  r_timer;

  logic              w_accept;
  logic              w_stepping;
  logic              w_pc_match;
  logic              w_hit;
  logic              w_paused;
  logic              w_match_any;
  logic [IDX_W-1:0]  w_match_idx;
  logic              w_free_any;
  logic [IDX_W-1:0]  w_free_idx;
  logic              w_bp_wr;
  logic [XLEN-1:0]   w_status;

  assign o_cmd_ready = rst_n && (r_state == S_IDLE) && !r_rsp_valid;
  assign w_accept    = i_cmd_valid && o_cmd_ready;
  assign w_stepping  = (r_state == S_STEP_RUN) || (r_state == S_STEP_STOP);
  assign w_hit       = !r_pause && !w_stepping && !(r_sup && (i_pc == r_sup_pc)) && w_pc_match;
  // A hit in the acceptance cycle counts as paused for that command.
  assign w_paused    = (r_pause || w_hit) && !i_mcu_busy;
  assign w_bp_wr     = w_accept && (i_cmd == C_BP_ADD) && !w_match_any && w_free_any;

  always_comb begin
    w_pc_match  = 1'b0;
    w_match_any = 1'b0;
    w_match_idx = '0;
    w_free_any  = 1'b0;
    w_free_idx  = '0;
    for (int i = NUM_BP - 1; i >= 0; i--) begin
      if (r_bp_valid[i] && (r_bp_addr[i] == i_pc)) w_pc_match = 1'b1;
      if (r_bp_valid[i] && (r_bp_addr[i] == i_cmd_addr)) begin
        w_match_any = 1'b1;
        w_match_idx = IDX_W'(i);
      end
      if (!r_bp_valid[i]) begin
        w_free_any = 1'b1;
        w_free_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    w_status             = '0;
    w_status[0]          = w_paused;
    w_status[8 +: CNT_W] = r_count;
  end

  always_ff @(posedge clk) begin
    if (w_bp_wr) r_bp_addr[w_free_idx] <= i_cmd_addr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_pause     <= 1'b0;
      r_sup       <= 1'b0;
      r_sup_pc    <= '0;
      r_bp_valid  <= '0;
      r_count     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_err   <= 1'b0;
      r_flush     <= 1'b0;
      r_mcu_reset <= 1'b0;
      r_bp_hit    <= 1'b0;
      r_mem_rd    <= 1'b0;
      r_mem_wr    <= 1'b0;
      r_rf_rd     <= 1'b0;
      r_rf_wr     <= 1'b0;
      r_timer     <= '0;
    end else begin
      r_flush     <= 1'b0;
      r_mcu_reset <= 1'b0;
      r_bp_hit    <= 1'b0;
      if (r_sup && (i_pc != r_sup_pc)) r_sup <= 1'b0;
      if (w_hit) begin
        r_pause  <= 1'b1;
        r_bp_hit <= 1'b1;
        r_flush  <= 1'b1;
      end

      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cmd       <= i_cmd;
            r_addr      <= i_cmd_addr;
            r_data      <= i_cmd_data;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
            case (i_cmd)
              C_PAUSE: begin
                r_pause <= 1'b1;
                if (i_mcu_busy) begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_PAUSING;
                end
              end
              C_RESUME: begin
                r_pause  <= 1'b0;
                r_sup    <= 1'b1;
                r_sup_pc <= i_pc;
              end
              C_STEP: begin
                if (!w_paused) begin
                  r_rsp_err <= 1'b1;
                end else begin
                  r_pause     <= 1'b0;
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_STEP_RUN;
                end
              end
              C_RESET: begin
                r_mcu_reset <= 1'b1;
                r_flush     <= 1'b1;
              end
              C_STATUS: r_rsp_data <= w_status;
              C_BP_ADD: begin
                if (w_bp_wr) begin
                  r_bp_valid[w_free_idx] <= 1'b1;
                  r_count                <= r_count + CNT_W'(1);
                end else if (!w_match_any) begin
                  r_rsp_err <= 1'b1;
                end
              end
              C_BP_RM: begin
                if (w_match_any) begin
                  r_bp_valid[w_match_idx] <= 1'b0;
                  r_count                 <= r_count - CNT_W'(1);
                end else begin
                  r_rsp_err <= 1'b1;
                end
              end
              C_MEM_RD, C_MEM_WR, C_REG_RD, C_REG_WR: begin
                if (!w_paused) begin
                  r_rsp_err <= 1'b1;
                end else begin
                  r_rsp_valid <= 1'b0;
                  r_state     <= S_ACCESS;
                  r_timer     <= '0;
                  r_mem_rd    <= (i_cmd == C_MEM_RD);
                  r_mem_wr    <= (i_cmd == C_MEM_WR);
                  r_rf_rd     <= (i_cmd == C_REG_RD);
                  r_rf_wr     <= (i_cmd == C_REG_WR);
                end
              end
              default: r_rsp_err <= 1'b1;
            endcase
          end
        end
        S_PAUSING: begin
          if (!i_mcu_busy) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end
        end
        S_STEP_RUN: begin
          r_pause <= 1'b1;
          r_state <= S_STEP_STOP;
        end
        S_STEP_STOP: begin
          if (!i_mcu_busy) begin
            r_rsp_data  <= i_pc;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
          end
        end
        S_ACCESS: begin
          if (i_mcu_ack || (r_timer == TMR_W'(TIMEOUT - 1))) begin
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_rf_rd     <= 1'b0;
            r_rf_wr     <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESPOND;
            if (!i_mcu_ack) r_rsp_err <= 1'b1;
            else if ((r_cmd == C_MEM_RD) || (r_cmd == C_REG_RD)) r_rsp_data <= i_mcu_rdata;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        S_RESPOND: begin
          if (i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_data  = r_rsp_data;
  assign o_rsp_err   = r_rsp_err;
  assign o_pause     = r_pause;
  assign o_flush     = r_flush;
  assign o_mcu_reset = r_mcu_reset;
  assign o_bp_hit    = r_bp_hit;
  assign o_mcu_addr  = r_addr;
  assign o_mcu_wdata = r_data;
  assign o_mem_rd    = r_mem_rd;
  assign o_mem_wr    = r_mem_wr;
  assign o_rf_rd     = r_rf_rd;
  assign o_rf_wr     = r_rf_wr;

endmodule
`default_nettype wire

// File: tb/tb_debug_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_debug_controller
// Desc     : Directed self-checking bench for debug_controller (NUM_BP = 2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_debug_controller;

  localparam int XLEN    = 32;
  localparam int NUM_BP  = 2;
  localparam int TIMEOUT = 255;

  localparam logic [3:0] C_PAUSE  = 4'd0;
  localparam logic [3:0] C_RESUME = 4'd1;
  localparam logic [3:0] C_STEP   = 4'd2;
  localparam logic [3:0] C_RESET  = 4'd3;
  localparam logic [3:0] C_STATUS = 4'd4;
  localparam logic [3:0] C_BP_ADD = 4'd5;
  localparam logic [3:0] C_BP_RM  = 4'd6;
  localparam logic [3:0] C_MEM_RD = 4'd7;
  localparam logic [3:0] C_MEM_WR = 4'd8;
  localparam logic [3:0] C_REG_RD = 4'd9;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      i_cmd = '0;
  logic [XLEN-1:0] i_cmd_addr = '0;
  logic [XLEN-1:0] i_cmd_data = '0;
  logic            i_cmd_valid = 1'b0;
  logic            o_cmd_ready;
  logic            o_rsp_valid;
  logic            i_rsp_ready = 1'b0;
  logic [XLEN-1:0] o_rsp_data;
  logic            o_rsp_err;
  logic [XLEN-1:0] i_pc = 32'hF0;
  logic            i_mcu_busy = 1'b0;
  logic            i_mcu_ack = 1'b0;
  logic [XLEN-1:0] i_mcu_rdata = '0;
  logic            o_pause, o_flush, o_mcu_reset, o_bp_hit;
  logic [XLEN-1:0] o_mcu_addr, o_mcu_wdata;
  logic            o_mem_rd, o_mem_wr, o_rf_rd, o_rf_wr;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  debug_controller #(.XLEN(XLEN), .NUM_BP(NUM_BP), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .i_cmd(i_cmd), .i_cmd_addr(i_cmd_addr), .i_cmd_data(i_cmd_data),
    .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
    .o_rsp_data(o_rsp_data), .o_rsp_err(o_rsp_err),
    .i_pc(i_pc), .i_mcu_busy(i_mcu_busy), .i_mcu_ack(i_mcu_ack), .i_mcu_rdata(i_mcu_rdata),
    .o_pause(o_pause), .o_flush(o_flush), .o_mcu_reset(o_mcu_reset), .o_bp_hit(o_bp_hit),
    .o_mcu_addr(o_mcu_addr), .o_mcu_wdata(o_mcu_wdata),
    .o_mem_rd(o_mem_rd), .o_mem_wr(o_mem_wr), .o_rf_rd(o_rf_rd), .o_rf_wr(o_rf_wr)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after acceptance.
  task automatic issue(input logic [3:0] c, input logic [31:0] a, input logic [31:0] d);
    chk("cmd_ready", o_cmd_ready, 1'b1);
    i_cmd = c; i_cmd_addr = a; i_cmd_data = d; i_cmd_valid = 1'b1;
    @(negedge clk);
    i_cmd_valid = 1'b0; i_cmd = '0; i_cmd_addr = '0; i_cmd_data = '0;
  endtask

  task automatic wait_rsp(output logic [31:0] d, output logic e, output int lat);
    lat = 1;
    while (!o_rsp_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    chk("rsp_arrived", o_rsp_valid, 1'b1);
    d = o_rsp_data;
    e = o_rsp_err;
    i_rsp_ready = 1'b1;
    @(negedge clk);
    i_rsp_ready = 1'b0;
  endtask

  task automatic txn(input string tag, input logic [3:0] c, input logic [31:0] a,
                     input logic [31:0] exp_d, input logic exp_e);
    logic [31:0] rd; logic re; int lat;
    issue(c, a, 32'h0);
    wait_rsp(rd, re, lat);
    chk({tag, "_data"}, rd, exp_d);
    chk({tag, "_err"}, re, exp_e);
    chk({tag, "_lat"}, lat, 1);
  endtask

  task automatic watch(input int n, output int hits, output int flushes);
    hits = 0; flushes = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      hits += int'(o_bp_hit);
      flushes += int'(o_flush);
    end
  endtask

  initial begin
    logic [31:0] rd; logic re; int lat, hits, fl, hi, lows;

    // Reset state
    #2;
    chk("rst_ready", o_cmd_ready, 1'b0);
    chk("rst_outs", {o_rsp_valid, o_rsp_err, o_pause, o_flush, o_mcu_reset, o_bp_hit,
                     o_mem_rd, o_mem_wr, o_rf_rd, o_rf_wr}, '0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_ready", o_cmd_ready, 1'b1);
    txn("status0", C_STATUS, 0, 32'h0, 1'b0);

    // Running MEM_RD: immediate error, held while rsp_ready is low
    issue(C_MEM_RD, 32'h40, 0);
    for (int i = 0; i < 10; i++) begin
      chk("hold", {o_rsp_valid, o_rsp_err, o_cmd_ready, o_mem_rd, (o_rsp_data == 0)}, 5'b11001);
      @(negedge clk);
    end
    wait_rsp(rd, re, lat);
    chk("run_rd_err", re, 1'b1);
    txn("illegal", 4'd12, 0, 32'h0, 1'b1);

    // Breakpoint table
    txn("add100", C_BP_ADD, 32'h100, 32'h0, 1'b0);
    txn("add104", C_BP_ADD, 32'h104, 32'h0, 1'b0);
    txn("add100d", C_BP_ADD, 32'h100, 32'h0, 1'b0);
    txn("status2", C_STATUS, 0, 32'h200, 1'b0);
    txn("add_full", C_BP_ADD, 32'h108, 32'h0, 1'b1);
    txn("rm_miss", C_BP_RM, 32'h200, 32'h0, 1'b1);
    txn("rm104", C_BP_RM, 32'h104, 32'h0, 1'b0);
    txn("status1", C_STATUS, 0, 32'h100, 1'b0);

    // pc ramps into the breakpoint
    i_pc = 32'hF8; @(negedge clk);
    i_pc = 32'hFC; @(negedge clk);
    i_pc = 32'h100;
    watch(5, hits, fl);
    chk("ramp_hits", hits, 1);
    chk("ramp_flush", fl, 1);
    chk("ramp_pause", o_pause, 1'b1);
    txn("status_p", C_STATUS, 0, 32'h101, 1'b0);

    // Resume on the breakpoint pc must not re-hit; leaving and returning does
    txn("resume", C_RESUME, 0, 32'h0, 1'b0);
    watch(4, hits, fl);
    chk("sup_hits", hits, 0);
    chk("sup_pause", o_pause, 1'b0);
    i_pc = 32'h104; @(negedge clk);
    i_pc = 32'h100;
    watch(4, hits, fl);
    chk("rehit", hits, 1);
    chk("rehit_pause", o_pause, 1'b1);

    // Single step with the MCU busy for 3 cycles
    issue(C_STEP, 0, 0);
    lows = int'(!o_pause);
    i_mcu_busy = 1'b1; i_pc = 32'h104;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      lows += int'(!o_pause);
      chk("step_busy_norsp", o_rsp_valid, 1'b0);
    end
    @(negedge clk);
    i_mcu_busy = 1'b0;
    wait_rsp(rd, re, lat);
    chk("step_lows", lows, 1);
    chk("step_pc", rd, 32'h104);
    chk("step_err", re, 1'b0);
    chk("step_pause", o_pause, 1'b1);

    // REG_RD acked on the 4th strobe cycle
    issue(C_REG_RD, 32'd5, 0);
    chk("rf_addr", o_mcu_addr, 32'd5);
    chk("rf_strobes", {o_mem_rd, o_mem_wr, o_rf_rd, o_rf_wr}, 4'b0010);
    hi = 0;
    for (int i = 0; i < 20 && !o_rsp_valid; i++) begin
      if (o_rf_rd) hi++;
      i_mcu_ack = o_rf_rd && (hi == 4);
      i_mcu_rdata = i_mcu_ack ? 32'hDEADBEEF : 32'h0;
      @(negedge clk);
    end
    i_mcu_ack = 1'b0;
    chk("rf_cycles", hi, 4);
    wait_rsp(rd, re, lat);
    chk("rf_data", rd, 32'hDEADBEEF);
    chk("rf_err", re, 1'b0);

    // MEM_WR never acked: timeout
    issue(C_MEM_WR, 32'h2000, 32'h12345678);
    chk("wr_addr", o_mcu_addr, 32'h2000);
    chk("wr_wdata", o_mcu_wdata, 32'h12345678);
    chk("wr_strobes", {o_mem_rd, o_mem_wr, o_rf_rd, o_rf_wr}, 4'b0100);
    hi = 0;
    for (int i = 0; i < 400 && !o_rsp_valid; i++) begin
      hi += int'(o_mem_wr);
      @(negedge clk);
    end
    chk("wr_cycles", hi, 255);
    wait_rsp(rd, re, lat);
    chk("wr_to_err", re, 1'b1);
    chk("wr_to_data", rd, 32'h0);

    // MEM_RD acked immediately
    issue(C_MEM_RD, 32'h40, 0);
    chk("mrd_strobes", {o_mem_rd, o_mem_wr, o_rf_rd, o_rf_wr}, 4'b1000);
    i_mcu_ack = 1'b1; i_mcu_rdata = 32'hA5A50F0F;
    @(negedge clk);
    i_mcu_ack = 1'b0; i_mcu_rdata = '0;
    chk("mrd_drop", o_mem_rd, 1'b0);
    wait_rsp(rd, re, lat);
    chk("mrd_data", rd, 32'hA5A50F0F);

    // MCU reset command
    issue(C_RESET, 0, 0);
    chk("rst_pulse", {o_mcu_reset, o_flush}, 2'b11);
    wait_rsp(rd, re, lat);
    chk("rst_pulse_end", {o_mcu_reset, o_flush}, 2'b00);
    txn("status_rst", C_STATUS, 0, 32'h101, 1'b0);

    // Breakpoint hit in the same cycle as an accepted RESUME
    txn("resume2", C_RESUME, 0, 32'h0, 1'b0);
    i_pc = 32'h200; @(negedge clk); @(negedge clk);
    i_pc = 32'h100;
    issue(C_RESUME, 0, 0);
    chk("sim_hit", {o_bp_hit, o_flush, o_pause}, 3'b110);
    wait_rsp(rd, re, lat);
    watch(3, hits, fl);
    chk("sim_nohit", hits, 0);
    chk("sim_pause", o_pause, 1'b0);

    // PAUSE while busy, then reset in the middle of a MEM_RD
    i_mcu_busy = 1'b1;
    issue(C_PAUSE, 0, 0);
    chk("pausing", {o_pause, o_rsp_valid}, 2'b10);
    i_mcu_busy = 1'b0;
    wait_rsp(rd, re, lat);
    chk("pause_err", re, 1'b0);
    issue(C_MEM_RD, 32'h80, 0);
    chk("mid_rd", o_mem_rd, 1'b1);
    @(negedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_drop", {o_mem_rd, o_rsp_valid, o_pause, o_cmd_ready}, 4'b0000);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel2_ready", o_cmd_ready, 1'b1);
    @(negedge clk);
    chk("rel2_norsp", o_rsp_valid, 1'b0);
    txn("status_clr", C_STATUS, 0, 32'h0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
